exc_ctrl: RTL and testbench

EXC_CTRL -- requirements
Module: exc_ctrl

---
 rtl/exc_ctrl.sv | 132 +++++++++++++
 tb/tb_exc_ctrl.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/exc_ctrl.sv
// Trap/exception sequencer: arbitrates syscall/break/teq requests, drives the
// CP0 handshake and PC redirect, and counts requests it had to reject.
module exc_ctrl #(
    parameter logic [31:0] VECTOR_ADDR = 32'h0040_0004,
    parameter int          CNT_W       = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             SYSCALL,
    input  logic             BREAK,
    input  logic             TEQ_HIT,
    input  logic             ERET_IN,
    input  logic [31:0]      STATUS,
    input  logic [31:0]      EXC_ADDR,
    output logic             EXCEPTION,
    output logic [4:0]       CAUSE,
    output logic             ERET,
    output logic [1:0]       PC_SEL,
    output logic [31:0]      NEW_PC,
    output logic             STALL,
    output logic             IN_HANDLER,
    output logic [CNT_W-1:0] DROP_CNT
);

    localparam logic [4:0] CAUSE_SYSCALL = 5'b01000;
    localparam logic [4:0] CAUSE_BREAK   = 5'b01001;
    localparam logic [4:0] CAUSE_TEQ     = 5'b01101;

    localparam logic [1:0] PC_SEQ    = 2'b00;
    localparam logic [1:0] PC_VECTOR = 2'b01;
    localparam logic [1:0] PC_EPC    = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_REDIR,
        S_HANDLER,
        S_RET
    } state_t;

    state_t     state;
    logic       any_req;
    logic       win_en;
    logic       accept;
    logic [4:0] win_code;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    // Only the highest-priority request is considered; if its enable is off the
    // whole cycle counts as a drop, lower-priority requests do not get a turn.
    always_comb begin
        any_req  = SYSCALL | BREAK | TEQ_HIT;
        win_code = CAUSE_BREAK;
        win_en   = STATUS[2];
        if (TEQ_HIT) begin
            win_code = CAUSE_TEQ;
            win_en   = STATUS[3];
        end else if (SYSCALL) begin
            win_code = CAUSE_SYSCALL;
            win_en   = STATUS[1];
        end
        accept = any_req & STATUS[0] & win_en;
    end

    // Outputs are registered together with the next state so nothing reaches a
    // port combinationally; each state's outputs are loaded on the edge entering it.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state      <= S_IDLE;
            CAUSE      <= '0;
            DROP_CNT   <= '0;
            EXCEPTION  <= 1'b0;
            ERET       <= 1'b0;
            STALL      <= 1'b0;
            IN_HANDLER <= 1'b0;
            PC_SEL     <= PC_SEQ;
            NEW_PC     <= '0;
        end else begin
            EXCEPTION  <= 1'b0;
            ERET       <= 1'b0;
            STALL      <= 1'b0;
            IN_HANDLER <= 1'b0;
            PC_SEL     <= PC_SEQ;
            NEW_PC     <= '0;
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        state     <= S_REQ;
                        CAUSE     <= win_code;
                        EXCEPTION <= 1'b1;
                        STALL     <= 1'b1;
                    end else if (any_req) begin
                        DROP_CNT <= sat_inc(DROP_CNT);
                    end
                end
                S_REQ: begin
                    state  <= S_REDIR;
                    PC_SEL <= PC_VECTOR;
                    NEW_PC <= VECTOR_ADDR;
                    STALL  <= 1'b1;
                end
                S_REDIR: begin
                    state      <= S_HANDLER;
                    IN_HANDLER <= 1'b1;
                end
                S_HANDLER: begin
                    if (any_req) begin
                        DROP_CNT <= sat_inc(DROP_CNT);
                    end
                    if (ERET_IN) begin
                        state  <= S_RET;
                        ERET   <= 1'b1;
                        PC_SEL <= PC_EPC;
                        NEW_PC <= EXC_ADDR;
                        STALL  <= 1'b1;
                    end else begin
                        IN_HANDLER <= 1'b1;
                    end
                end
                S_RET: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_exc_ctrl.sv
// Scoreboard bench for exc_ctrl: stimulus queues expected redirect/exception
// cycles, a negedge monitor pops and compares them as the DUT presents them.
module tb_exc_ctrl;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        SYSCALL = 1'b0;
    logic        BREAK = 1'b0;
    logic        TEQ_HIT = 1'b0;
    logic        ERET_IN = 1'b0;
    logic [31:0] STATUS = 32'h0;
    logic [31:0] EXC_ADDR = 32'h0;
    logic        EXCEPTION;
    logic [4:0]  CAUSE;
    logic        ERET;
    logic [1:0]  PC_SEL;
    logic [31:0] NEW_PC;
    logic        STALL;
    logic        IN_HANDLER;
    logic [7:0]  DROP_CNT;

    localparam logic [31:0] VEC = 32'h0040_0004;
    localparam logic [31:0] EPC = 32'h0040_0120;

    typedef struct packed {
        logic        exc;
        logic        eret;
        logic [4:0]  cause;
        logic [1:0]  pc_sel;
        logic [31:0] new_pc;
        logic        stall;
        logic        in_h;
    } ev_t;

    ev_t exp_q[$];
    int  checks = 0;
    int  errors = 0;

    exc_ctrl dut (
        .CLK(CLK), .RST(RST), .SYSCALL(SYSCALL), .BREAK(BREAK), .TEQ_HIT(TEQ_HIT),
        .ERET_IN(ERET_IN), .STATUS(STATUS), .EXC_ADDR(EXC_ADDR),
        .EXCEPTION(EXCEPTION), .CAUSE(CAUSE), .ERET(ERET), .PC_SEL(PC_SEL),
        .NEW_PC(NEW_PC), .STALL(STALL), .IN_HANDLER(IN_HANDLER), .DROP_CNT(DROP_CNT)
    );

    always #5 CLK = ~CLK;

    function automatic ev_t ev_req(input logic [4:0] c);
        return '{exc: 1'b1, eret: 1'b0, cause: c, pc_sel: 2'b00, new_pc: 32'h0, stall: 1'b1, in_h: 1'b0};
    endfunction
    function automatic ev_t ev_redir(input logic [4:0] c);
        return '{exc: 1'b0, eret: 1'b0, cause: c, pc_sel: 2'b01, new_pc: VEC, stall: 1'b1, in_h: 1'b0};
    endfunction
    function automatic ev_t ev_ret(input logic [4:0] c, input logic [31:0] a);
        return '{exc: 1'b0, eret: 1'b1, cause: c, pc_sel: 2'b10, new_pc: a, stall: 1'b1, in_h: 1'b0};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check_idle_outputs(input string name, input logic [7:0] drop);
        chk({name, "_exc"}, {31'h0, EXCEPTION}, 32'h0);
        chk({name, "_eret"}, {31'h0, ERET}, 32'h0);
        chk({name, "_stall"}, {31'h0, STALL}, 32'h0);
        chk({name, "_inh"}, {31'h0, IN_HANDLER}, 32'h0);
        chk({name, "_pcsel"}, {30'h0, PC_SEL}, 32'h0);
        chk({name, "_newpc"}, NEW_PC, 32'h0);
        chk({name, "_drop"}, {24'h0, DROP_CNT}, {24'h0, drop});
    endtask

    // Enter the handler via one request pulse (REQ, REDIR, then HANDLER).
    task automatic enter(input logic s, input logic b, input logic t, input logic [4:0] c);
        exp_q.push_back(ev_req(c));
        exp_q.push_back(ev_redir(c));
        SYSCALL = s; BREAK = b; TEQ_HIT = t;
        tick();
        SYSCALL = 1'b0; BREAK = 1'b0; TEQ_HIT = 1'b0;
        tick();
        tick();
    endtask

    task automatic leave(input logic [4:0] c, input logic brk);
        exp_q.push_back(ev_ret(c, EXC_ADDR));
        ERET_IN = 1'b1; BREAK = brk;
        tick();
        ERET_IN = 1'b0; BREAK = 1'b0;
        tick();
    endtask

    always @(negedge CLK) begin
        if (EXCEPTION || ERET || PC_SEL != 2'b00) begin
            ev_t act;
            act = '{exc: EXCEPTION, eret: ERET, cause: CAUSE, pc_sel: PC_SEL,
                    new_pc: NEW_PC, stall: STALL, in_h: IN_HANDLER};
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_event: got %h expected none", act);
            end else begin
                ev_t e;
                e = exp_q.pop_front();
                if (act !== e) begin
                    errors++;
                    $display("FAIL event: got %h expected %h", act, e);
                end
            end
        end
    end

    initial begin
        tick();
        tick();
        check_idle_outputs("reset", 8'd0);
        chk("reset_cause", {27'h0, CAUSE}, 32'h0);
        RST = 1'b0;
        tick();

        // Basic syscall entry and return
        STATUS = 32'h0000_000F;
        EXC_ADDR = EPC;
        enter(1'b1, 1'b0, 1'b0, 5'b01000);
        chk("sys_inh", {31'h0, IN_HANDLER}, 32'h1);
        chk("sys_stall", {31'h0, STALL}, 32'h0);
        leave(5'b01000, 1'b0);
        check_idle_outputs("after_ret", 8'd0);

        // Priority teq over syscall
        enter(1'b1, 1'b0, 1'b1, 5'b01101);
        chk("prio_cause", {27'h0, CAUSE}, 32'h0000_000D);
        chk("prio_drop", {24'h0, DROP_CNT}, 32'h0);
        leave(5'b01101, 1'b0);

        // Masked requests
        STATUS = 32'h0000_000B;
        BREAK = 1'b1; tick(); BREAK = 1'b0; tick();
        chk("mask_brk_drop", {24'h0, DROP_CNT}, 32'd1);
        chk("mask_cause_hold", {27'h0, CAUSE}, 32'h0000_000D);
        STATUS = 32'h0;
        SYSCALL = 1'b1; tick(); SYSCALL = 1'b0; tick();
        chk("mask_sys_drop", {24'h0, DROP_CNT}, 32'd2);

        // STATUS cleared mid-sequence, then ERET with a simultaneous break
        STATUS = 32'h0000_000F;
        exp_q.push_back(ev_req(5'b01001));
        exp_q.push_back(ev_redir(5'b01001));
        BREAK = 1'b1; tick(); BREAK = 1'b0;
        STATUS = 32'h0;
        tick(); tick();
        chk("status_chg_inh", {31'h0, IN_HANDLER}, 32'h1);
        leave(5'b01001, 1'b1);
        chk("eret_win_drop", {24'h0, DROP_CNT}, 32'd3);
        chk("eret_win_inh", {31'h0, IN_HANDLER}, 32'h0);

        // Saturation while nested requests are held in the handler
        STATUS = 32'h0000_000F;
        enter(1'b1, 1'b0, 1'b0, 5'b01000);
        SYSCALL = 1'b1;
        repeat (300) tick();
        SYSCALL = 1'b0;
        chk("sat_drop", {24'h0, DROP_CNT}, 32'd255);
        chk("sat_inh", {31'h0, IN_HANDLER}, 32'h1);
        chk("sat_cause", {27'h0, CAUSE}, 32'h0000_0008);
        leave(5'b01000, 1'b0);
        chk("sat_drop_hold", {24'h0, DROP_CNT}, 32'd255);

        // Asynchronous reset during REDIR
        exp_q.push_back(ev_req(5'b01000));
        SYSCALL = 1'b1; tick(); SYSCALL = 1'b0;
        tick();
        chk("pre_rst_pcsel", {30'h0, PC_SEL}, 32'h1);
        RST = 1'b1;
        #1;
        check_idle_outputs("async_rst", 8'd0);
        chk("async_rst_cause", {27'h0, CAUSE}, 32'h0);
        tick();
        RST = 1'b0;
        tick();
        enter(1'b1, 1'b0, 1'b0, 5'b01000);
        chk("post_rst_inh", {31'h0, IN_HANDLER}, 32'h1);
        leave(5'b01000, 1'b0);
        tick();
        tick();
        chk("queue_drained", exp_q.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
